// File: rtl/circ_buffer_write_arbiter.sv
// Circular word buffer shared by two producers and one consumer.
// Round-robin write arbitration, wrap-around pointers, occupancy/full/empty status.
// Optional sticky overrun flag enabled by defining CIRC_ARB_OVERRUN_EN; otherwise tied to 0.
module circ_buffer_write_arbiter #(
  parameter int unsigned buff_size = 4,
  parameter int unsigned word_size = 8,
  parameter int unsigned ptr_width = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_0,
  input  logic [word_size-1:0] data_0,
  input  logic                 req_1,
  input  logic [word_size-1:0] data_1,
  output logic                 grant_0,
  output logic                 grant_1,
  input  logic                 rd_en,
  output logic [word_size-1:0] data_out,
  output logic                 full,
  output logic                 empty,
  output logic [ptr_width:0]   count,
  output logic                 overrun
);

  localparam logic [ptr_width:0] FullCount = (ptr_width + 1)'(buff_size);

  typedef enum logic [0:0] {StPri0, StPri1} arb_state_e;

  arb_state_e           state_q, state_d;
  logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_width:0]   count_q, count_d;
  logic [word_size-1:0] mem_q [buff_size];

  logic                 wr_en;
  logic [word_size-1:0] wr_data;
  logic                 rd_accept;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign data_out = mem_q[rd_ptr_q];

  // Arbitration: grants from requests, full and priority state; next priority state.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    state_d = state_q;
    if (!full) begin
      if (req_0 && req_1) begin
        if (state_q == StPri0) grant_0 = 1'b1;
        else                   grant_1 = 1'b1;
      end else if (req_0) begin
        grant_0 = 1'b1;
      end else if (req_1) begin
        grant_1 = 1'b1;
      end
    end
    if (grant_0) state_d = StPri1;
    if (grant_1) state_d = StPri0;
  end

  // Priority state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StPri0;
    else       state_q <= state_d;
  end

  // Pointer and occupancy next-state; a pop on an empty buffer is ignored.
  always_comb begin
    wr_en     = grant_0 | grant_1;
    wr_data   = grant_0 ? data_0 : data_1;
    rd_accept = rd_en & ~empty;
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = rd_accept ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({wr_en, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so data_out reads 0 afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < buff_size; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef CIRC_ARB_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky flag: any request seen while full.
  always_comb begin
    overrun_d = overrun_q | ((req_0 | req_1) & full);
  end

  // Overrun flag register.
  always_ff @(posedge clock) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_circ_buffer_write_arbiter.sv
// Self-checking bench: queue-based model compared every cycle plus directed literal checks.
module tb_circ_buffer_write_arbiter;

  localparam int BuffSize = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_0, req_1, rd_en;
  logic [7:0] data_0, data_1, data_out;
  logic       grant_0, grant_1, full, empty, overrun;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  circ_buffer_write_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .req_0    (req_0),
    .data_0   (data_0),
    .req_1    (req_1),
    .data_1   (data_1),
    .grant_0  (grant_0),
    .grant_1  (grant_1),
    .rd_en    (rd_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: FIFO contents as a queue, who holds priority, sticky overrun.
  logic [7:0] mq[$];
  bit         m_prio;   // 0: requester 0 wins a tie
  bit         m_ovr;
  bit         m_valid = 1'b0;

  initial begin : model
    bit eg0, eg1, mfull;
    forever begin
      @(negedge clock);
      if (!reset && m_valid) begin
        mfull = (mq.size() == BuffSize);
        eg0 = !mfull && req_0 && (!req_1 || m_prio == 1'b0);
        eg1 = !mfull && req_1 && (!req_0 || m_prio == 1'b1);
        check("m_grant_0", grant_0, eg0);
        check("m_grant_1", grant_1, eg1);
        check("m_count", count, mq.size());
        check("m_full", full, mfull);
        check("m_empty", empty, mq.size() == 0);
        check("m_overrun", overrun, m_ovr);
        if (mq.size() > 0) check("m_data_out", data_out, mq[0]);
      end
      @(posedge clock);
      if (reset) begin
        mq.delete();
        m_prio  = 1'b0;
        m_ovr   = 1'b0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        mfull = (mq.size() == BuffSize);
        eg0 = !mfull && req_0 && (!req_1 || m_prio == 1'b0);
        eg1 = !mfull && req_1 && (!req_0 || m_prio == 1'b1);
`ifdef CIRC_ARB_OVERRUN_EN
        if ((req_0 || req_1) && mfull) m_ovr = 1'b1;
`endif
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        if (eg0) begin
          mq.push_back(data_0);
          m_prio = 1'b1;
        end else if (eg1) begin
          mq.push_back(data_1);
          m_prio = 1'b0;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] seq5 [6];
    seq5 = '{8'h40, 8'h41, 8'h42, 8'h50, 8'h51, 8'h52};
    reset  = 1'b1;
    req_0  = 1'b0;
    req_1  = 1'b0;
    rd_en  = 1'b0;
    data_0 = 8'h00;
    data_1 = 8'h00;
    repeat (2) tick();
    reset = 1'b0;

    // Reset then idle.
    @(negedge clock);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_grant_0", grant_0, 0);
    check("rst_grant_1", grant_1, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data_out", data_out, 8'h00);

    // Single write then pop.
    tick(); req_0 = 1'b1; data_0 = 8'hA1;
    @(negedge clock); check("t2_grant_0", grant_0, 1);
    tick(); req_0 = 1'b0;
    @(negedge clock); check("t2_count", count, 1); check("t2_data", data_out, 8'hA1);
    tick(); rd_en = 1'b1;
    tick(); rd_en = 1'b0;
    @(negedge clock); check("t2_empty", empty, 1);

    // Both requesting: alternate grants, fill, then pop in order.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    req_0 = 1'b1; req_1 = 1'b1; data_0 = 8'h10; data_1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t3_grant_0", grant_0, (i % 2) == 0);
      check("t3_grant_1", grant_1, (i % 2) == 1);
      tick();
    end
    @(negedge clock);
    check("t3_full", full, 1);
    check("t3_count", count, 4);
    check("t3_nogrant", {grant_0, grant_1}, 2'b00);
    tick(); req_0 = 1'b0; req_1 = 1'b0;
`ifdef CIRC_ARB_OVERRUN_EN
    @(negedge clock); check("t3_overrun", overrun, 1);
    tick();
`endif
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t3_pop", data_out, ((i % 2) == 0) ? 8'h10 : 8'h20);
      tick();
    end
    rd_en = 1'b0;
    @(negedge clock); check("t3_empty", empty, 1);

    // Full boundary: pop while full defers the write by one cycle.
    tick(); req_0 = 1'b1; data_0 = 8'h30;
    repeat (4) tick();
    req_0 = 1'b0;
    @(negedge clock); check("t4_count_full", count, 4);
    tick(); req_1 = 1'b1; data_1 = 8'h55; rd_en = 1'b1;
    @(negedge clock); check("t4_nogrant", grant_1, 0); check("t4_count4", count, 4);
    tick(); rd_en = 1'b0;
    @(negedge clock); check("t4_grant_1", grant_1, 1); check("t4_count3", count, 3);
    tick(); req_1 = 1'b0;
    @(negedge clock); check("t4_count_back", count, 4);
`ifdef CIRC_ARB_OVERRUN_EN
    check("t4_overrun", overrun, 1);
`endif

    // Drain, fill to 3, then simultaneous write and pop with wrap.
    tick(); rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t5_drain", data_out, (i < 3) ? 8'h30 : 8'h55);
      tick();
    end
    rd_en = 1'b0;
    req_0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_0 = 8'h40 + 8'(i);
      tick();
    end
    req_0 = 1'b0;
    @(negedge clock); check("t5_count3", count, 3);
    tick(); req_0 = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_0 = 8'h50 + 8'(i);
      @(negedge clock);
      check("t5_steady_count", count, 3);
      check("t5_steady_data", data_out, seq5[i]);
      tick();
    end
    req_0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t5_tail", data_out, 8'h53 + 8'(i));
      tick();
    end
    rd_en = 1'b0;
    @(negedge clock); check("t5_empty", empty, 1);

    // Reset mid-stream at count 2 with requester 1 holding priority.
    tick(); req_0 = 1'b1; data_0 = 8'h60;
    tick(); data_0 = 8'h61;
    tick(); req_0 = 1'b0;
    @(negedge clock); check("t6_count2", count, 2);
    tick(); reset = 1'b1; req_0 = 1'b1; req_1 = 1'b1; data_0 = 8'h70; data_1 = 8'h71;
    tick(); reset = 1'b0;
    @(negedge clock);
    check("t6_count0", count, 0);
    check("t6_empty", empty, 1);
    check("t6_data0", data_out, 8'h00);
    check("t6_grant_0", grant_0, 1);
    check("t6_grant_1", grant_1, 0);
    check("t6_overrun", overrun, 0);
    tick(); req_0 = 1'b0; req_1 = 1'b0;
    @(negedge clock); check("t6_first", data_out, 8'h70); check("t6_count1", count, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circ_buffer_write_arbiter.md
Name: circ_buffer_write_arbiter

Overview:
- Shares a 4-entry circular word buffer between two producers (requester 0 and requester 1) and one consumer.
- Performs round-robin write arbitration and manages the write and read pointers with wrap-around.
- Tracks occupancy and provides full and empty status.
- Sits between the two upstream data sources and the downstream consumer; it owns the storage array and all of its sequencing.

Parameters:
- buff_size, 4, number of buffer entries (power of two, at least 2).
- word_size, 8, data width in bits.
- ptr_width, 2, pointer width; must equal log2(buff_size).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_0  input  1  requester 0 wants to write data_0 this cycle.
- data_0  input  word_size  requester 0 write data.
- req_1  input  1  requester 1 wants to write data_1 this cycle.
- data_1  input  word_size  requester 1 write data.
- grant_0  output  1  combinational; high means data_0 is written at this clock edge.
- grant_1  output  1  combinational; high means data_1 is written at this clock edge.
- rd_en  input  1  consumer pops the head entry this cycle.
- data_out  output  word_size  combinational view of the entry at rd_ptr; valid only when empty is 0.
- full  output  1  count == buff_size.
- empty  output  1  count == 0.
- count  output  ptr_width+1  current occupancy, 0..buff_size.
- overrun  output  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Interface (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- Reset, sampled at a rising edge of clock:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - All entries cleared to 0.
  - Arbiter state = PRI0.
  - Outputs: full = 0, empty = 1, data_out = 0, overrun = 0.
  - Reset overrides all other activity in the same cycle, including mid-stream operation; all pending data is lost.
- Arbiter FSM, two states (PRI0 = requester 0 has priority, PRI1 = requester 1 has priority):
  - A write is possible only when full == 0.
  - Both requesting: grant goes to the priority holder.
  - One requesting: that requester is granted regardless of state.
  - After grant_0 the next state is PRI1; after grant_1 the next state is PRI0; with no grant the state holds.
  - At most one grant per cycle. Grants are combinational from req_x, full and state.
  - A denied requester must hold req and data; there is no queueing inside the block.
- Write: on a grant, entry[wr_ptr] <= granted data, and wr_ptr increments, wrapping from buff_size-1 to 0.
- Read: a pop is accepted when rd_en is high and empty is 0. rd_ptr then increments with the same wrap rule. rd_en while empty is ignored with no state change.
- Count update:
  - +1 on a write with no pop.
  - -1 on a pop with no write.
  - Unchanged on a simultaneous write and pop, or when neither occurs.
- Full boundary: when full, no grant is issued even if a pop occurs in the same cycle. The pop proceeds and the write waits one cycle.
- Empty boundary: when empty, a write proceeds; data_out reflects the new entry from the next cycle.
- data_out is never bypassed from the write inputs.
- Latency: a granted word is visible on data_out, if it is the head, one cycle after its grant.

Optional Feature:
- Macro: CIRC_ARB_OVERRUN_EN.
- Defined: overrun is set at the clock edge ending any cycle in which (req_0 or req_1) is high while full is 1. It stays set until reset.
- Not defined: overrun is tied to 0 and no flag register exists. The port is always present so the interface is identical in both builds.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, grant_0=grant_1=0, overrun=0.
- req_0 alone with data_0=8'hA1 for one cycle -> grant_0=1 that cycle; next cycle count=1 and data_out=8'hA1; rd_en for one cycle -> empty=1.
- req_0 and req_1 both held with data_0=8'h10 and data_1=8'h20, no reads -> grants go 0,1,0,1; then full=1 with count=4, further grants 0; popping four times yields 10,20,10,20.
- With the buffer full, hold req_1 with data_1=8'h55 and pulse rd_en once -> no grant during the pop cycle; grant_1=1 the next cycle; count goes 4→3→4; with the macro defined, overrun=1.
- Fill to 3 entries, then assert req_0 and rd_en together for 6 cycles -> count stays 3 and both pointers wrap past 3→0; read order matches write order.
- Assert reset mid-stream at count=2 -> next cycle count=0, empty=1, data_out=0, arbiter back to PRI0 (a simultaneous request from both requesters grants requester 0).
